// File: rtl/cart_pkg.sv
// cart_pkg: shared constants and types for the MBC1 cartridge mapper.
//   - CPU / ROM / RAM address widths and bank field widths
//   - 8 KiB region selectors (cpu_addr[15:13]) for register and RAM windows
//   - bank_regs_t: bank1 / bank2 / mode / ram_en register bundle
//   - rd_src_e: which source supplies a pending read's data
package cart_pkg;

   localparam int CPU_AW     = 16;
   localparam int ROM_AW     = 21;
   localparam int RAM_AW     = 15;
   localparam int ROM_OFS_W  = 14;
   localparam int RAM_OFS_W  = 13;
   localparam int ROM_BANK_W = ROM_AW - ROM_OFS_W;
   localparam int RAM_BANK_W = RAM_AW - RAM_OFS_W;

   // cpu_addr[15:13] selects an 8 KiB window
   localparam logic [2:0] REGION_RAM_EN = 3'b000;
   localparam logic [2:0] REGION_BANK1  = 3'b001;
   localparam logic [2:0] REGION_BANK2  = 3'b010;
   localparam logic [2:0] REGION_MODE   = 3'b011;
   localparam logic [2:0] REGION_RAM    = 3'b101;

   typedef struct packed {
      logic [4:0] bank1;
      logic [1:0] bank2;
      logic       mode;
      logic       ram_en;
   } bank_regs_t;

   localparam bank_regs_t BANK_REGS_RST = '{bank1: 5'd1, bank2: 2'd0, mode: 1'b0, ram_en: 1'b0};

   typedef enum logic [1:0] {
      SRC_FF  = 2'd0,
      SRC_ROM = 2'd1,
      SRC_RAM = 2'd2
   } rd_src_e;

   function automatic logic in_rom(input logic [CPU_AW-1:0] addr);
      return ~addr[15];
   endfunction

   function automatic logic in_ram(input logic [CPU_AW-1:0] addr);
      return addr[15:13] == REGION_RAM;
   endfunction

endpackage

// File: rtl/cart_mbc1_regs.sv
// cart_mbc1_regs: MBC1 control registers and their write decode.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en         CPU write strobe (writes win over a simultaneous read)
//   addr, wdata   CPU address / write data
//   regs          current bank1 / bank2 / mode / ram_en
// Build option: CART_RAM_EN -- when undefined, ram_en stays 0 and
// writes to the RAM-enable window are ignored.
module cart_mbc1_regs
   import cart_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CPU_AW-1:0] addr,
   input  logic [7:0]        wdata,
   output bank_regs_t        regs
);

   bank_regs_t regs_d;
   bank_regs_t regs_q;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         case (addr[15:13])
            REGION_RAM_EN: begin
`ifdef CART_RAM_EN
               regs_d.ram_en = (wdata[3:0] == 4'hA);
`endif
            end
            // bank 0 cannot be mapped into the switchable window
            REGION_BANK1: regs_d.bank1 = (wdata[4:0] == 5'd0) ? 5'd1 : wdata[4:0];
            REGION_BANK2: regs_d.bank2 = wdata[1:0];
            REGION_MODE:  regs_d.mode  = wdata[0];
            default: ;
         endcase
      end
`ifndef CART_RAM_EN
      regs_d.ram_en = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= BANK_REGS_RST;
      else     regs_q <= regs_d;
   end

   assign regs = regs_q;

endmodule

// File: rtl/cart_mbc1.sv
// cart_mbc1: MBC1 cartridge mapper (ROM/RAM banking, 1-cycle read path).
// Parameters: ROM_BANKS_LOG2 (1..7), RAM_BANKS_LOG2 (0..2).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_addr/rd/wr/wdata      CPU bus request (single-cycle strobes)
//   cpu_rdata, cpu_rvalid     read return, one cycle after cpu_rd
//   rom_addr / rom_data       synchronous ROM (address now, data next cycle)
//   ram_addr / ram_we / ram_wdata / ram_rdata   cartridge RAM
// Build option: CART_RAM_EN -- enables cartridge RAM; when undefined,
// ram_we and ram_addr are tied to 0 and the RAM window reads 8'hFF.
module cart_mbc1
   import cart_pkg::*;
#(
   parameter int ROM_BANKS_LOG2 = 5,
   parameter int RAM_BANKS_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CPU_AW-1:0] cpu_addr,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   localparam int ROM_MASK_I = (1 << ROM_BANKS_LOG2) - 1;
   localparam logic [ROM_BANK_W-1:0] ROM_MASK = ROM_MASK_I[ROM_BANK_W-1:0];

   bank_regs_t regs;

   cart_mbc1_regs u_regs (
      .clk   (clk),
      .rst   (rst),
      .wr_en (cpu_wr),
      .addr  (cpu_addr),
      .wdata (cpu_wdata),
      .regs  (regs)
   );

   // ROM mapping: lower window is bank 0 unless mode 1 lets bank2 in
   logic [ROM_BANK_W-1:0] rom_bank;

   always_comb begin
      rom_bank = '0;
      if (cpu_addr[14])   rom_bank = {regs.bank2, regs.bank1};
      else if (regs.mode) rom_bank = {regs.bank2, 5'b0};
   end

   assign rom_addr = {rom_bank & ROM_MASK, cpu_addr[ROM_OFS_W-1:0]};

`ifdef CART_RAM_EN
   localparam int RAM_MASK_I = (1 << RAM_BANKS_LOG2) - 1;
   localparam logic [RAM_BANK_W-1:0] RAM_MASK = RAM_MASK_I[RAM_BANK_W-1:0];

   logic [RAM_BANK_W-1:0] ram_bank;

   assign ram_bank = (regs.mode ? regs.bank2 : '0) & RAM_MASK;
   assign ram_addr = {ram_bank, cpu_addr[RAM_OFS_W-1:0]};
   assign ram_we   = cpu_wr & ~rst & in_ram(cpu_addr) & regs.ram_en;
`else
   assign ram_addr = '0;
   assign ram_we   = 1'b0;
`endif

   assign ram_wdata = cpu_wdata;

   // Read path: the source is chosen at request time, the data itself
   // arrives from the synchronous memories in the following cycle.
   logic       rvalid_d, rvalid_q;
   rd_src_e    src_d, src_q;
   logic [7:0] hold_d, hold_q;
   logic [7:0] rd_mux;

   always_comb begin
      rvalid_d = cpu_rd & ~cpu_wr;
      src_d    = SRC_FF;
      if (in_rom(cpu_addr))                      src_d = SRC_ROM;
      else if (in_ram(cpu_addr) && regs.ram_en)  src_d = SRC_RAM;
   end

   always_comb begin
      case (src_q)
         SRC_ROM: rd_mux = rom_data;
         SRC_RAM: rd_mux = ram_rdata;
         default: rd_mux = 8'hFF;
      endcase
      hold_d = rvalid_q ? rd_mux : hold_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         src_q    <= SRC_FF;
         hold_q   <= 8'hFF;
      end else begin
         rvalid_q <= rvalid_d;
         src_q    <= src_d;
         hold_q   <= hold_d;
      end
   end

   assign cpu_rvalid = rvalid_q;
   assign cpu_rdata  = rvalid_q ? rd_mux : hold_q;

endmodule
